// File: rtl/decode_hazard_stage_pkg.sv
// Shared opcode, ALUOP and FSM state definitions for the decode/hazard stage.
package decode_hazard_stage_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_STW = 4'b0111;

  localparam logic [1:0] ALU_BR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_LDW = 2'b10;
  localparam logic [1:0] ALU_STW = 2'b11;

  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} dh_state_e;

endpackage

// File: rtl/dh_regfile.sv
// 8-entry register file: posedge write, two asynchronous reads with write-through.
module dh_regfile
  import decode_hazard_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr1,
  input  logic [2:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_r [8];

  // Storage update: clear on reset, otherwise write the WB result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports see a same-cycle write to the addressed entry.
  always_comb begin
    if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_r[raddr1];
    end
    if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_r[raddr2];
    end
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage with operand forwarding, load-use bubbles and a branch-shadow FSM.
module decode_hazard_stage
  import decode_hazard_stage_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BR_SHADOW = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IR_VALID,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic              FLUSH,
  input  logic [2:0]        CC,
  input  logic [1:0]        EX_OP,
  input  logic [1:0]        MEM_OP,
  input  logic [2:0]        EX_DR,
  input  logic [2:0]        MEM_DR,
  input  logic [2:0]        WB_DR,
  input  logic [DATA_W-1:0] AGEX_RESULT,
  input  logic [DATA_W-1:0] MEM_RESULT,
  input  logic [DATA_W-1:0] WB_RESULT,
  input  logic              WB_ENABLE,
  output logic              STALL,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OPERAND1,
  output logic [DATA_W-1:0] OPERAND2,
  output logic [DATA_W-1:0] PC_OUT,
  output logic [DATA_W-1:0] PC_OFFSET,
  output logic [DATA_W-1:0] MEM_OFFSET,
  output logic [1:0]        ALUOP,
  output logic [2:0]        DR,
  output logic              BRANCH
);

  localparam logic [2:0] SHADOW_INIT = 3'(BR_SHADOW);

  dh_state_e         state_r;
  logic [2:0]        cnt_r;
  logic              out_valid_r, branch_r;
  logic [DATA_W-1:0] op1_r, op2_r, pc_r, pc_off_r, mem_off_r;
  logic [1:0]        aluop_r;
  logic [2:0]        dr_r;

  logic              is_br_s, is_add_s, is_ldw_s, is_stw_s, opcode_ok_s;
  logic [1:0]        aluop_s;
  logic [2:0]        sr1_s, sr2_s;
  logic              use1_s, use2_s, load_use_s, run_s, br_issue_s, issue_s, taken_s;
  logic [DATA_W-1:0] rf1_s, rf2_s, fwd1_s, fwd2_s, op2_s, imm5_s;

  dh_regfile #(.DATA_W(DATA_W)) u_regfile (
    .CLK    (CLK),
    .RESET  (RESET),
    .we     (WB_ENABLE),
    .waddr  (WB_DR),
    .wdata  (WB_RESULT),
    .raddr1 (sr1_s),
    .raddr2 (sr2_s),
    .rdata1 (rf1_s),
    .rdata2 (rf2_s)
  );

  // WB forwarding is covered by the register file's write-through path.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [2:0] sr, input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    if ((EX_OP == ALU_ADD) && (EX_DR == sr)) begin
      v = AGEX_RESULT;
    end else if (((MEM_OP == ALU_ADD) || (MEM_OP == ALU_LDW)) && (MEM_DR == sr)) begin
      v = MEM_RESULT;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  // Opcode classification.
  always_comb begin
    is_br_s  = 1'b0;
    is_add_s = 1'b0;
    is_ldw_s = 1'b0;
    is_stw_s = 1'b0;
    aluop_s  = ALU_BR;
    case (IR[15:12])
      OP_BR:   begin is_br_s  = 1'b1; aluop_s = ALU_BR;  end
      OP_ADD:  begin is_add_s = 1'b1; aluop_s = ALU_ADD; end
      OP_LDW:  begin is_ldw_s = 1'b1; aluop_s = ALU_LDW; end
      OP_STW:  begin is_stw_s = 1'b1; aluop_s = ALU_STW; end
      default: begin aluop_s  = ALU_BR; end
    endcase
  end

  // Source selection, operand muxing and hazard detection.
  always_comb begin
    sr1_s = IR[8:6];
    if (is_stw_s) begin
      sr2_s = IR[11:9];
    end else begin
      sr2_s = IR[2:0];
    end
    use1_s  = is_add_s | is_ldw_s | is_stw_s;
    use2_s  = (is_add_s & ~IR[5]) | is_stw_s;
    fwd1_s  = fwd_sel(sr1_s, rf1_s);
    fwd2_s  = fwd_sel(sr2_s, rf2_s);
    imm5_s  = {{(DATA_W-5){IR[4]}}, IR[4:0]};
    if ((is_add_s && IR[5]) || is_ldw_s) begin
      op2_s = imm5_s;
    end else begin
      op2_s = fwd2_s;
    end
    opcode_ok_s = is_br_s | is_add_s | is_ldw_s | is_stw_s;
    run_s       = (state_r == RUN) & IR_VALID & ~FLUSH;
    load_use_s  = run_s & (EX_OP == ALU_LDW) &
                  ((use1_s & (EX_DR == sr1_s)) | (use2_s & (EX_DR == sr2_s)));
    br_issue_s  = run_s & is_br_s & (IR != 16'h0000);
    issue_s     = run_s & ~load_use_s & opcode_ok_s & ~(is_br_s & (IR == 16'h0000));
    taken_s     = (IR[11] & CC[2]) | (IR[10] & CC[1]) | (IR[9] & CC[0]);
  end

  assign STALL = (state_r == SHADOW) | load_use_s;

  // Branch-shadow FSM and registered decode outputs; any non-issue latches a bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= RUN;
      cnt_r       <= 3'd0;
      out_valid_r <= 1'b0;
      branch_r    <= 1'b0;
      op1_r       <= {DATA_W{1'b0}};
      op2_r       <= {DATA_W{1'b0}};
      pc_r        <= {DATA_W{1'b0}};
      pc_off_r    <= {DATA_W{1'b0}};
      mem_off_r   <= {DATA_W{1'b0}};
      aluop_r     <= 2'b00;
      dr_r        <= 3'd0;
    end else begin
      if (FLUSH) begin
        state_r <= RUN;
        cnt_r   <= 3'd0;
      end else begin
        case (state_r)
          RUN: begin
            if (br_issue_s) begin
              state_r <= SHADOW;
              cnt_r   <= SHADOW_INIT;
            end
          end
          SHADOW: begin
            if (cnt_r <= 3'd1) begin
              state_r <= RUN;
              cnt_r   <= 3'd0;
            end else begin
              cnt_r <= cnt_r - 3'd1;
            end
          end
          default: begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
          end
        endcase
      end
      if (issue_s) begin
        out_valid_r <= 1'b1;
        branch_r    <= is_br_s & taken_s;
        op1_r       <= fwd1_s;
        op2_r       <= op2_s;
        pc_r        <= PC_IN;
        pc_off_r    <= {{(DATA_W-9){IR[8]}}, IR[8:0]};
        mem_off_r   <= {{(DATA_W-6){IR[5]}}, IR[5:0]};
        aluop_r     <= aluop_s;
        dr_r        <= IR[11:9];
      end else begin
        out_valid_r <= 1'b0;
        branch_r    <= 1'b0;
        op1_r       <= {DATA_W{1'b0}};
        op2_r       <= {DATA_W{1'b0}};
        pc_r        <= {DATA_W{1'b0}};
        pc_off_r    <= {DATA_W{1'b0}};
        mem_off_r   <= {DATA_W{1'b0}};
        aluop_r     <= 2'b00;
        dr_r        <= 3'd0;
      end
    end
  end

  assign OUT_VALID  = out_valid_r;
  assign BRANCH     = branch_r;
  assign OPERAND1   = op1_r;
  assign OPERAND2   = op2_r;
  assign PC_OUT     = pc_r;
  assign PC_OFFSET  = pc_off_r;
  assign MEM_OFFSET = mem_off_r;
  assign ALUOP      = aluop_r;
  assign DR         = dr_r;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed bench: a 16-bit instance (shadow 2) and a 32-bit instance (shadow 3) share stimulus.
module tb_decode_hazard_stage;

  logic        clk, reset, ir_valid, flush, wb_enable;
  logic [15:0] ir;
  logic [31:0] pc_in, agex_result, mem_result, wb_result;
  logic [2:0]  cc, ex_dr, mem_dr, wb_dr;
  logic [1:0]  ex_op, mem_op;

  logic        a_stall, a_valid, a_branch;
  logic [15:0] a_op1, a_op2, a_pc, a_pcoff, a_memoff;
  logic [1:0]  a_aluop;
  logic [2:0]  a_dr;

  logic        b_stall, b_valid, b_branch;
  logic [31:0] b_op1, b_op2, b_pc, b_pcoff, b_memoff;
  logic [1:0]  b_aluop;
  logic [2:0]  b_dr;

  int checks = 0;
  int errors = 0;

  decode_hazard_stage #(.DATA_W(16), .BR_SHADOW(2)) dut16 (
    .CLK(clk), .RESET(reset), .IR_VALID(ir_valid), .IR(ir), .PC_IN(pc_in[15:0]),
    .FLUSH(flush), .CC(cc), .EX_OP(ex_op), .MEM_OP(mem_op), .EX_DR(ex_dr),
    .MEM_DR(mem_dr), .WB_DR(wb_dr), .AGEX_RESULT(agex_result[15:0]),
    .MEM_RESULT(mem_result[15:0]), .WB_RESULT(wb_result[15:0]), .WB_ENABLE(wb_enable),
    .STALL(a_stall), .OUT_VALID(a_valid), .OPERAND1(a_op1), .OPERAND2(a_op2),
    .PC_OUT(a_pc), .PC_OFFSET(a_pcoff), .MEM_OFFSET(a_memoff), .ALUOP(a_aluop),
    .DR(a_dr), .BRANCH(a_branch)
  );

  decode_hazard_stage #(.DATA_W(32), .BR_SHADOW(3)) dut32 (
    .CLK(clk), .RESET(reset), .IR_VALID(ir_valid), .IR(ir), .PC_IN(pc_in),
    .FLUSH(flush), .CC(cc), .EX_OP(ex_op), .MEM_OP(mem_op), .EX_DR(ex_dr),
    .MEM_DR(mem_dr), .WB_DR(wb_dr), .AGEX_RESULT(agex_result),
    .MEM_RESULT(mem_result), .WB_RESULT(wb_result), .WB_ENABLE(wb_enable),
    .STALL(b_stall), .OUT_VALID(b_valid), .OPERAND1(b_op1), .OPERAND2(b_op2),
    .PC_OUT(b_pc), .PC_OFFSET(b_pcoff), .MEM_OFFSET(b_memoff), .ALUOP(b_aluop),
    .DR(b_dr), .BRANCH(b_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ir_valid = 1'b0; ir = 16'h0000; flush = 1'b0; cc = 3'b000;
    ex_op = 2'b00; mem_op = 2'b00; ex_dr = 3'd0; mem_dr = 3'd0; wb_dr = 3'd0;
    agex_result = 32'h0; mem_result = 32'h0; wb_result = 32'h0; wb_enable = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] v);
    wb_enable = 1'b1; wb_dr = r; wb_result = v;
    tick();
    wb_enable = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; ir_valid = 1'b1; ir = 16'h1283; pc_in = 32'h0000_1234;
    tick(); tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", a_valid); end
    checks++; if (a_op1 !== 16'h0 || a_pc !== 16'h0) begin errors++; $display("FAIL rst_outs got %h/%h exp 0", a_op1, a_pc); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %h exp 0", a_stall); end
    reset = 1'b0;
    tick();
    checks++; if (a_valid !== 1'b1 || a_op1 !== 16'h0 || a_op2 !== 16'h0) begin
      errors++; $display("FAIL rst_rf got v%h %h %h exp 1 0 0", a_valid, a_op1, a_op2); end
  endtask

  task automatic test_forward();
    idle(); wb_write(3'd3, 32'h3);
    ir_valid = 1'b1; ir = 16'h1283; pc_in = 32'h3000;
    ex_op = 2'b01; ex_dr = 3'd2; agex_result = 32'h5;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL fwd_stall got %h exp 0", a_stall); end
    tick();
    checks++; if (a_op1 !== 16'h0005 || a_op2 !== 16'h0003) begin
      errors++; $display("FAIL fwd_ex got %h %h exp 0005 0003", a_op1, a_op2); end
    checks++; if (a_valid !== 1'b1 || a_aluop !== 2'b01 || a_dr !== 3'd1 || a_pc !== 16'h3000) begin
      errors++; $display("FAIL fwd_ctl got v%h a%h d%h pc%h exp 1 1 1 3000", a_valid, a_aluop, a_dr, a_pc); end
    // EX beats MEM; WB write-through feeds the other operand
    agex_result = 32'h55; mem_op = 2'b01; mem_dr = 3'd2; mem_result = 32'h66;
    wb_enable = 1'b1; wb_dr = 3'd3; wb_result = 32'h99;
    tick();
    wb_enable = 1'b0;
    checks++; if (a_op1 !== 16'h0055 || a_op2 !== 16'h0099) begin
      errors++; $display("FAIL fwd_prio got %h %h exp 0055 0099", a_op1, a_op2); end
    // STW in EX does not forward; LDW in MEM does; R3 keeps the WB value
    ex_op = 2'b11; mem_op = 2'b10;
    tick();
    checks++; if (a_op1 !== 16'h0066 || a_op2 !== 16'h0099) begin
      errors++; $display("FAIL fwd_mem got %h %h exp 0066 0099", a_op1, a_op2); end
  endtask

  task automatic test_load_use();
    idle(); wb_write(3'd4, 32'h44);
    ir_valid = 1'b1; ir = 16'h1121; ex_op = 2'b10; ex_dr = 3'd4;
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", a_stall); end
    tick();
    checks++; if (a_valid !== 1'b0 || a_branch !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v%h b%h exp 0 0", a_valid, a_branch); end
    ex_op = 2'b00;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %h exp 0", a_stall); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_op1 !== 16'h0044 || a_op2 !== 16'h0001 || a_dr !== 3'd0) begin
      errors++; $display("FAIL lu_redecode got v%h %h %h d%h exp 1 0044 0001 0", a_valid, a_op1, a_op2, a_dr); end
    // immediate ADD does not use IR[2:0]
    ex_op = 2'b10; ex_dr = 3'd1;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_imm got %h exp 0", a_stall); end
    ir = 16'h1283; ex_dr = 3'd3;
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_sr2 got %h exp 1", a_stall); end
    ir = 16'h7A83; ex_dr = 3'd5;
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stw got %h exp 1", a_stall); end
    tick();
    ex_op = 2'b00;
    tick();
    checks++; if (a_valid !== 1'b1 || a_aluop !== 2'b11 || a_memoff !== 16'h0003 || a_dr !== 3'd5) begin
      errors++; $display("FAIL stw_dec got v%h a%h m%h d%h exp 1 3 0003 5", a_valid, a_aluop, a_memoff, a_dr); end
  endtask

  task automatic test_branch();
    idle(); ir_valid = 1'b1; ir = 16'h0E05; cc = 3'b010; pc_in = 32'h3010;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL br_prestall got %h exp 0", a_stall); end
    tick();
    checks++; if (a_branch !== 1'b1 || a_valid !== 1'b1 || a_pcoff !== 16'h0005) begin
      errors++; $display("FAIL br_issue got b%h v%h off%h exp 1 1 0005", a_branch, a_valid, a_pcoff); end
    checks++; if (a_aluop !== 2'b00 || a_dr !== 3'd7 || a_pc !== 16'h3010) begin
      errors++; $display("FAIL br_fields got a%h d%h pc%h exp 0 7 3010", a_aluop, a_dr, a_pc); end
    ir = 16'h1283;
    for (int i = 0; i < 2; i++) begin
      checks++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin
        errors++; $display("FAIL br_shadow%0d got %h/%h exp 1/1", i, a_stall, b_stall); end
      tick();
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL br_squash%0d got %h exp 0", i, a_valid); end
    end
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b1) begin
      errors++; $display("FAIL br_end got %h/%h exp 0/1", a_stall, b_stall); end
    tick();
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL br_resume got %h exp 1", a_valid); end
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL br_end32 got %h exp 0", b_stall); end
    ir = 16'h09FF;
    tick();
    checks++; if (a_branch !== 1'b0 || a_valid !== 1'b1 || a_pcoff !== 16'hFFFF) begin
      errors++; $display("FAIL br_nt got b%h v%h off%h exp 0 1 ffff", a_branch, a_valid, a_pcoff); end
    ir_valid = 1'b0;
    tick(); tick(); tick();
    ir_valid = 1'b1; ir = 16'h0000;
    tick();
    ir_valid = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_stall !== 1'b0) begin
      errors++; $display("FAIL br_zero got v%h s%h exp 0 0", a_valid, a_stall); end
  endtask

  task automatic test_write_through();
    idle(); ir_valid = 1'b1; ir = 16'h7D80;
    wb_enable = 1'b1; wb_dr = 3'd6; wb_result = 32'hBEEF;
    tick();
    checks++; if (a_op1 !== 16'hBEEF || a_op2 !== 16'hBEEF || a_aluop !== 2'b11) begin
      errors++; $display("FAIL wt got %h %h a%h exp beef beef 3", a_op1, a_op2, a_aluop); end
    ex_op = 2'b01; ex_dr = 3'd6; agex_result = 32'h1234; wb_result = 32'h4321;
    tick();
    checks++; if (a_op1 !== 16'h1234 || a_op2 !== 16'h1234) begin
      errors++; $display("FAIL wt_ex_wins got %h %h exp 1234 1234", a_op1, a_op2); end
  endtask

  task automatic test_flush();
    idle(); ir_valid = 1'b1; ir = 16'h0E05; cc = 3'b010;
    tick();
    flush = 1'b1; ir = 16'h1283;
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL fl_inshadow got %h exp 1", a_stall); end
    tick();
    flush = 1'b0;
    checks++; if (a_stall !== 1'b0 || a_valid !== 1'b0 || a_branch !== 1'b0 || a_pcoff !== 16'h0) begin
      errors++; $display("FAIL fl_shadow got s%h v%h b%h off%h exp 0 0 0 0", a_stall, a_valid, a_branch, a_pcoff); end
    tick();
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL fl_run got %h exp 1", a_valid); end
    ir = 16'h0E05; flush = 1'b1;
    tick();
    flush = 1'b0; ir_valid = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_branch !== 1'b0 || a_stall !== 1'b0) begin
      errors++; $display("FAIL fl_br got v%h b%h s%h exp 0 0 0", a_valid, a_branch, a_stall); end
    ir_valid = 1'b1; ir = 16'h5000;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL nop_stall got %h exp 0", a_stall); end
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL nop_valid got %h exp 0", a_valid); end
  endtask

  task automatic test_reset_mid();
    idle(); ir_valid = 1'b1; ir = 16'h0E05; cc = 3'b010;
    tick();
    reset = 1'b1; ir = 16'h1283; pc_in = 32'h4444;
    tick();
    reset = 1'b0;
    checks++; if (a_stall !== 1'b0 || a_valid !== 1'b0 || a_op2 !== 16'h0 || a_pc !== 16'h0 || a_dr !== 3'd0) begin
      errors++; $display("FAIL rm_outs got s%h v%h %h pc%h d%h exp all 0", a_stall, a_valid, a_op2, a_pc, a_dr); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_op2 !== 16'h0) begin
      errors++; $display("FAIL rm_rfclear got v%h %h exp 1 0000", a_valid, a_op2); end
  endtask

  task automatic test_width32();
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_write(3'd1, 32'h8000_0010);
    ir_valid = 1'b1; ir = 16'h127F;
    tick();
    checks++; if (b_op2 !== 32'hFFFF_FFFF || b_op1 !== 32'h8000_0010) begin
      errors++; $display("FAIL w32_add got %h %h exp 80000010 ffffffff", b_op1, b_op2); end
    checks++; if (a_op2 !== 16'hFFFF || a_op1 !== 16'h0010) begin
      errors++; $display("FAIL w16_add got %h %h exp 0010 ffff", a_op1, a_op2); end
    ir = 16'h647E;
    tick();
    checks++; if (b_op2 !== 32'hFFFF_FFFE || b_memoff !== 32'hFFFF_FFFE || b_pcoff !== 32'h0000_007E) begin
      errors++; $display("FAIL w32_ldw got %h m%h p%h exp fffffffe fffffffe 7e", b_op2, b_memoff, b_pcoff); end
    checks++; if (b_aluop !== 2'b10 || b_dr !== 3'd2 || b_valid !== 1'b1) begin
      errors++; $display("FAIL w32_ctl got a%h d%h v%h exp 2 2 1", b_aluop, b_dr, b_valid); end
  endtask

  initial begin
    idle(); reset = 1'b1; pc_in = 32'h0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_write_through();
    test_flush();
    test_reset_mid();
    test_width32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised instruction-decode stage for the 5-stage pipeline, sitting between fetch and AGEX. It contains the 8-entry register file and extends the decode function with:
- a configurable datapath width;
- full EX/MEM/WB forwarding;
- load-use hazard detection with bubble insertion;
- a branch-shadow state machine that squashes fetched instructions for a programmable number of cycles after a branch.

## Interface
Parameters:
- DATA_W, 16, datapath/register width (≥16); immediates sign-extended to DATA_W
- BR_SHADOW, 2, cycles (1..7) fetch is held/squashed after a BR is issued

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- IR_VALID  in  1  IR holds a real instruction this cycle
- IR  in  16  instruction word
- PC_IN  in  DATA_W  PC of IR
- FLUSH  in  1  redirect from later stage; kills current decode
- CC  in  3  {N,Z,P} condition codes
- EX_OP, MEM_OP  in  2 each  ALUOP of instruction in EX / MEM (01 ADD, 10 LDW)
- EX_DR, MEM_DR, WB_DR  in  3 each  destination registers
- AGEX_RESULT, MEM_RESULT, WB_RESULT  in  DATA_W each  forwarding values
- WB_ENABLE  in  1  register-file write enable
- STALL  out  1  hold fetch/PC this cycle (combinational)
- OUT_VALID  out  1  registered outputs carry a real instruction
- OPERAND1, OPERAND2, PC_OUT, PC_OFFSET, MEM_OFFSET  out  DATA_W each  registered
- ALUOP  out  2  registered (00 BR, 01 ADD, 10 LDW, 11 STW)
- DR  out  3  registered IR[11:9]
- BRANCH  out  1  registered taken-branch flag

## Operation
- Decode:
  - SR1=IR[8:6]; SR2=IR[11:9] for STW, else IR[2:0].
  - OPERAND2 = SEXT(IR[4:0]) for ADD with IR[5]=1 and for LDW.
  - PC_OFFSET=SEXT(IR[8:0]); MEM_OFFSET=SEXT(IR[5:0]).
  - Opcodes other than 0000/0001/0110/0111 decode as NOP (OUT_VALID=0).
- Source usage:
  - ADD: SR1, plus SR2 when IR[5]=0.
  - LDW: SR1.
  - STW: SR1, SR2.
  - BR: none.
- Forwarding priority per operand: EX (EX_OP=01, DR match) > MEM (MEM_OP∈{01,10}, match) > WB (WB_ENABLE, match) > regfile.
- Register file writes on posedge when WB_ENABLE. Same-cycle read of WB_DR returns WB_RESULT (write-through).
- Load-use: EX_OP=10 and EX_DR equals a used source.
  - STALL=1; outputs latch a bubble (OUT_VALID=0, BRANCH=0); IR is re-decoded next cycle.
- BR with IR≠0 and IR_VALID:
  - BRANCH = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P); issued with OUT_VALID=1.
  - FSM moves RUN→SHADOW with counter=BR_SHADOW.
- FSM:
  - RUN: normal decode.
  - SHADOW: STALL=1; IR is ignored; OUT_VALID=0; counter decrements each cycle; returns to RUN on the cycle counter reaches 1.
- A BR word of all zeros (IR=0) is a NOP.
- FLUSH: next edge latches a bubble and forces RUN, counter=0. FLUSH has priority over load-use and branch issue.
- IR_VALID=0: bubble latched; no stall.

## Timing
- Decode latency: 1 cycle (IR at edge n → outputs valid after edge n).
- STALL is combinational from IR/EX_* and state. It is asserted in the cycle the hazard is seen, and for exactly BR_SHADOW cycles following a branch issue.
- A load-use stall lasts 1 cycle when the LDW advances normally.
- Reset (synchronous):
  - all registered outputs 0; state=RUN; counter=0;
  - register file entries 0.
  - RESET during SHADOW aborts the shadow.
- Simultaneous WB write and EX/MEM match: EX/MEM value wins.
- Simultaneous FLUSH and BR decode: the BR is discarded, with no shadow.

## Structure
- Shared package:
  - opcode constants (OP_BR, OP_ADD, OP_LDW, OP_STW);
  - ALUOP encodings;
  - FSM state enum {RUN, SHADOW}.
- One sub-module: `dh_regfile` (8×DATA_W, posedge write, 2 async reads with write-through). Sign extension is inline.

## Test plan
- ADD R1,R2,R3 with EX_OP=01, EX_DR=2, AGEX_RESULT=0x0005, regfile R3=0x0003 → OPERAND1=0x0005, OPERAND2=0x0003, ALUOP=01, DR=1, OUT_VALID=1 next cycle.
- LDW in EX (EX_OP=10, EX_DR=4) with decode ADD R0,R4,#1 → STALL=1, bubble latched. Next cycle (EX_OP=00) → OPERAND1 from regfile, OPERAND2=0x0001.
- BRnzp (IR=0x0E05), CC=010, BR_SHADOW=2 → BRANCH=1, PC_OFFSET=0x0005. STALL high 2 cycles, and IR presented in those cycles yields OUT_VALID=0.
- WB_ENABLE, WB_DR=6, WB_RESULT=0xBEEF, with decode STW R6,R6,#0 in the same cycle → OPERAND1=OPERAND2=0xBEEF.
- FLUSH during SHADOW and RESET asserted mid-ADD → next cycle state RUN, STALL=0, all outputs 0.
- DATA_W=32: ADD R1,R1,#-1 (IR=0x127F) → OPERAND2=0xFFFF_FFFF.
